// File: rtl/alu_pkg.sv
// Shared opcode encoding and statistics constants for the ALU opcode responder.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    INV    = 2'b10,
    RED_OR = 2'b11
  } opcode_e;

  localparam int unsigned OPCODE_W = 2;
  localparam int unsigned NUM_OPS  = 4;
  localparam int unsigned STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Circular buffer of completed ALU responses with occupancy count and full/empty flags.
module alu_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic [0:0],
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage holds payload only; validity is tracked by the counter.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_op_responder.sv
// ALU opcode responder: computes ADD/SUB/INV/RED_OR per request and buffers results.
// Optional per-opcode pop counters are built when ALU_OP_STATS_EN is defined.
module alu_op_responder
  import alu_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_opcode,
  input  logic [W-1:0]      req_a,
  input  logic [W-1:0]      req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic [1:0]        rsp_opcode,
  output logic              rsp_flag,
  input  logic [1:0]        stat_sel,
  output logic [STAT_W-1:0] stat_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [W-1:0] result;
    opcode_e      opcode;
    logic         flag;
  } rsp_entry_t;

  rsp_entry_t    req_entry;
  rsp_entry_t    head_entry;
  logic [W:0]    sum_w;
  logic [W:0]    diff_w;
  logic          req_fire;
  logic          rsp_fire;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Extra MSB of the widened sum/difference is the carry-out/borrow.
  always_comb begin
    sum_w            = {1'b0, req_a} + {1'b0, req_b};
    diff_w           = {1'b0, req_a} - {1'b0, req_b};
    req_entry.opcode = opcode_e'(req_opcode);
    req_entry.result = '0;
    req_entry.flag   = 1'b0;
    unique case (req_entry.opcode)
      ADD: begin
        req_entry.result = sum_w[W-1:0];
        req_entry.flag   = sum_w[W];
      end
      SUB: begin
        req_entry.result = diff_w[W-1:0];
        req_entry.flag   = diff_w[W];
      end
      INV:    req_entry.result = ~req_a;
      RED_OR: req_entry.result = W'(|req_b);
    endcase
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign req_ready = !fifo_full || rsp_fire;
  assign req_fire  = req_valid && req_ready;

  alu_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (rsp_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire),
    .pop_i   (rsp_fire),
    .wdata_i (req_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head payload is masked to zero whenever nothing is buffered.
  assign rsp_result = fifo_empty ? '0   : head_entry.result;
  assign rsp_opcode = fifo_empty ? 2'b00 : head_entry.opcode;
  assign rsp_flag   = fifo_empty ? 1'b0 : head_entry.flag;

`ifdef ALU_OP_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_OPS];
  logic [STAT_W-1:0] stat_d [NUM_OPS];

  // Saturating per-opcode count of delivered results.
  always_comb begin
    stat_d = stat_q;
    if (rsp_fire && (stat_q[head_entry.opcode] != STAT_MAX)) begin
      stat_d[head_entry.opcode] = stat_q[head_entry.opcode] + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_count = stat_q[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_alu_op_responder.sv
// Scoreboard bench for alu_op_responder: driver pushes expected results, monitor checks pops.
module tb_alu_op_responder;

  localparam int unsigned W     = 2;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_opcode;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [1:0]   rsp_opcode;
  logic         rsp_flag;
  logic [1:0]   stat_sel;
  logic [15:0]  stat_count;

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   op;
    logic         flg;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  alu_op_responder #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_opcode (rsp_opcode),
    .rsp_flag   (rsp_flag),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the presented head against the scoreboard, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_spurious_valid", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_payload", 32'({rsp_result, rsp_opcode, rsp_flag}),
                32'({sb[0].res, sb[0].op, sb[0].flg}));
          if (rsp_ready) begin
            if (sb[0].lat) check("rsp_latency", 32'(cyc - sb[0].acc), 32'd1);
            void'(sb.pop_front());
          end
        end
      end else begin
        check("rsp_idle_zero", 32'({rsp_result, rsp_opcode, rsp_flag}), 32'd0);
      end
    end
  end

  // Present a request, push its expected response on acceptance, return at posedge+1.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic flg, input bit imm, input bit lat);
    bit   done = 1'b0;
    exp_t e;
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.res = res;
        e.op  = op;
        e.flg = flg;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end else if (imm && i == 0) begin
        check("req_ready_imm", 32'(req_ready), 32'd1);
      end
    end
    if (!done) check("req_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [1:0] op, input int a, input int b,
                                output logic [W-1:0] r, output logic f);
    int m;
    int s;
    m = 1 << W;
    case (op)
      2'd0: begin s = a + b; r = W'(s % m); f = (s >= m); end
      2'd1: begin r = W'((a - b + m) % m); f = (a < b); end
      2'd2: begin r = W'(m - 1 - a); f = 1'b0; end
      default: begin r = W'(b != 0); f = 1'b0; end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    logic         f;
    logic [1:0]   op;
    int           a;
    int           b;
    logic [15:0]  exp_add;
    logic [15:0]  exp_ror;

    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; stat_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_payload", 32'({rsp_result, rsp_opcode, rsp_flag}), 32'd0);
    check("rst_stat_count", 32'(stat_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back opcodes with A=2, B=1, then carry/borrow cases.
    rsp_ready = 1'b1;
    send(2'b00, 2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 1'b1);
    send(2'b01, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    send(2'b10, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    send(2'b11, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    send(2'b00, 2'd3, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1);
    send(2'b01, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1);
    req_valid = 1'b0;
    drain();

    // Back-pressure: fill, stall the third, release with a same-cycle pop/accept.
    rsp_ready = 1'b0;
    send(2'b00, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    send(2'b01, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    req_valid = 1'b1; req_opcode = 2'b10; req_a = '0; req_b = '0;
    repeat (3) begin
      @(negedge clk);
      check("req_ready_full", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    send(2'b10, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
    req_valid = 1'b0;
    drain();

    // Asynchronous reset with two results buffered.
    rsp_ready = 1'b0;
    send(2'b00, 2'd1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0);
    send(2'b01, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    check("two_buffered_valid", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_payload", 32'({rsp_result, rsp_opcode, rsp_flag}), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Per-opcode statistics: 3 ADD pops and 1 RED_OR pop.
    send(2'b00, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    send(2'b00, 2'd1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1);
    send(2'b00, 2'd2, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1);
    send(2'b11, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    req_valid = 1'b0;
    drain();
`ifdef ALU_OP_STATS_EN
    exp_add = 16'd3;
    exp_ror = 16'd1;
`else
    exp_add = 16'd0;
    exp_ror = 16'd0;
`endif
    stat_sel = 2'b00; #1;
    check("stat_add", 32'(stat_count), 32'(exp_add));
    stat_sel = 2'b11; #1;
    check("stat_red_or", 32'(stat_count), 32'(exp_ror));
    stat_sel = 2'b01; #1;
    check("stat_sub", 32'(stat_count), 32'd0);
    @(posedge clk); #1;

    // Streaming: random requests, one result per cycle, checked against the model.
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 3));
      b  = int'($urandom_range(0, 3));
      model(op, a, b, r, f);
      send(op, W'(a), W'(b), r, f, 1'b1, 1'b1);
    end
    req_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
